// File: rtl/bundle_accumulator.sv
// rtl/bundle_accumulator.sv - per-lane saturating signed majority accumulator with sign resolve
module bundle_accumulator #(
    parameter int DIM    = 32,
    parameter int CNT_W  = 16,
    parameter int BEAT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sel_valid,
    input  logic [2*DIM-1:0]    sel_bits,
    input  logic                finish,
    input  logic [DIM-1:0]      tie_bits,
    output logic                busy,
    output logic                out_valid,
    output logic [DIM-1:0]      out_bits,
    output logic [BEAT_W-1:0]   beat_cnt,
    output logic                sat_flag
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE} state_t;

    // Symmetric clamp range: the most negative code is never produced.
    localparam logic signed [CNT_W:0] CNT_MAX = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0] CNT_MIN = -CNT_MAX;
    localparam logic [BEAT_W-1:0]     BEAT_MAX = '1;

    state_t                    state_q, state_d;
    logic signed [CNT_W-1:0]   cnt_q [DIM];
    logic signed [CNT_W-1:0]   cnt_d [DIM];
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      sat_q, sat_d;
    logic                      out_valid_q, out_valid_d;
    logic [DIM-1:0]            out_bits_q, out_bits_d;
    logic                      accept;
    logic signed [CNT_W:0]     lane_step;
    logic signed [CNT_W:0]     lane_sum;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        out_bits_d  = out_bits_q;
        lane_step   = '0;
        lane_sum    = '0;
        accept      = sel_valid && (start || (state_q == S_ACCUM));

        // A restart arriving in RESOLVE drops the pending result.
        if (state_q == S_RESOLVE && !start) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                out_bits_d[i] = (cnt_q[i] == '0) ? tie_bits[i] : cnt_q[i][CNT_W-1];
            end
        end

        if (start) begin
            for (int i = 0; i < DIM; i++) begin
                cnt_d[i] = '0;
            end
            beat_d = '0;
            sat_d  = 1'b0;
        end

        if (accept) begin
            for (int i = 0; i < DIM; i++) begin
                case (sel_bits[2*i +: 2])
                    2'b01:   lane_step = {{CNT_W{1'b0}}, 1'b1};
                    2'b11:   lane_step = '1;
                    default: lane_step = '0;
                endcase
                lane_sum = {cnt_d[i][CNT_W-1], cnt_d[i]} + lane_step;
                if (lane_sum > CNT_MAX) begin
                    cnt_d[i] = CNT_MAX[CNT_W-1:0];
                    sat_d    = 1'b1;
                end else if (lane_sum < CNT_MIN) begin
                    cnt_d[i] = CNT_MIN[CNT_W-1:0];
                    sat_d    = 1'b1;
                end else begin
                    cnt_d[i] = lane_sum[CNT_W-1:0];
                end
            end
            if (beat_d != BEAT_MAX) begin
                beat_d = beat_d + 1'b1;
            end
        end

        if (start) begin
            state_d = S_ACCUM;
        end else begin
            case (state_q)
                S_ACCUM:   if (finish) state_d = S_RESOLVE;
                S_RESOLVE: state_d = S_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DIM; i++) begin
                cnt_q[i] <= '0;
            end
            beat_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign beat_cnt  = beat_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_bundle_accumulator.sv
// tb/tb_bundle_accumulator.sv - directed and randomized checks of bundle_accumulator
module tb_bundle_accumulator;

    localparam int DIM = 4;
    localparam int CNT_W = 3;
    localparam int BEAT_W = 4;
    localparam int CMAX = 3;
    localparam int BMAX = 15;

    logic             clk = 1'b0;
    logic             rst, start, sel_valid, finish;
    logic [2*DIM-1:0] sel_bits;
    logic [DIM-1:0]   tie_bits;
    logic             busy, out_valid, sat_flag;
    logic [DIM-1:0]   out_bits;
    logic [BEAT_W-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 accumulating, 2 resolving
    int       m_state;
    int       m_cnt [DIM];
    int       m_beat;
    bit       m_sat;
    bit       m_ov;
    logic [DIM-1:0] m_ob;

    bundle_accumulator #(.DIM(DIM), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid),
        .sel_bits(sel_bits), .finish(finish), .tie_bits(tie_bits),
        .busy(busy), .out_valid(out_valid), .out_bits(out_bits),
        .beat_cnt(beat_cnt), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        int v;
        int s;
        bit accept;
        if (rst) begin
            m_state = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_beat = 0; m_sat = 0; m_ov = 0; m_ob = '0;
        end else begin
            m_ov = (m_state == 2) && !start;
            if (m_ov) begin
                for (int i = 0; i < DIM; i++)
                    m_ob[i] = (m_cnt[i] > 0) ? 1'b0 : (m_cnt[i] < 0) ? 1'b1 : tie_bits[i];
            end
            accept = sel_valid && (start || m_state == 1);
            if (start) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
                m_beat = 0; m_sat = 0;
            end
            if (accept) begin
                for (int i = 0; i < DIM; i++) begin
                    v = sel_bits[2*i +: 2];
                    s = m_cnt[i] + ((v == 1) ? 1 : (v == 3) ? -1 : 0);
                    if (s > CMAX) begin s = CMAX; m_sat = 1; end
                    if (s < -CMAX) begin s = -CMAX; m_sat = 1; end
                    m_cnt[i] = s;
                end
                if (m_beat < BMAX) m_beat++;
            end
            if (start) m_state = 1;
            else if (m_state == 1 && finish) m_state = 2;
            else if (m_state == 2) m_state = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; start = 0; sel_valid = 0; finish = 0; sel_bits = '0;
    endtask

    task automatic beat(input logic [2*DIM-1:0] b);
        sel_valid = 1; sel_bits = b; step(); sel_valid = 0; sel_bits = '0;
    endtask

    task automatic test_reset();
        quiet(); rst = 1; step(); step(); rst = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_bits !== 4'b0000) begin errors++; $display("FAIL reset_out_bits got %b want 0000", out_bits); end
        checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got %b want 0", sat_flag); end
    endtask

    task automatic test_basic();
        quiet(); start = 1; step(); start = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy); end
        beat(8'b00_01_11_01);
        beat(8'b00_11_11_01);
        beat(8'b00_00_01_11);
        tie_bits = 4'b0100; finish = 1; step(); finish = 0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_resolve_cycle got ov=%b busy=%b want ov=0 busy=1", out_valid, busy); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        checks++; if (out_bits !== 4'b0110) begin errors++; $display("FAIL basic_out_bits got %b want 0110", out_bits); end
        checks++; if (beat_cnt !== 4'd3) begin errors++; $display("FAIL basic_beat_cnt got %0d want 3", beat_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy); end
        tie_bits = 4'b1001; step();
        checks++; if (out_valid !== 1'b0 || out_bits !== 4'b0110) begin errors++; $display("FAIL basic_hold got ov=%b bits=%b want ov=0 bits=0110", out_valid, out_bits); end
    endtask

    task automatic test_finish_with_beat();
        logic [DIM-1:0] t;
        t = 4'($urandom);
        quiet(); start = 1; sel_valid = 1; sel_bits = 8'b01010101; step(); start = 0;
        sel_bits = 8'b11111111; finish = 1; tie_bits = t; step(); quiet();
        step();
        checks++; if (out_valid !== 1'b1 || out_bits !== t) begin errors++; $display("FAIL finish_beat got ov=%b bits=%b want ov=1 bits=%b", out_valid, out_bits, t); end
        checks++; if (beat_cnt !== 4'd2) begin errors++; $display("FAIL finish_beat_cnt got %0d want 2", beat_cnt); end
    endtask

    task automatic test_saturation();
        logic [DIM-1:0] t;
        t = 4'($urandom);
        quiet(); start = 1; step(); start = 0;
        repeat (5) beat(8'b01010101);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_pos got %b want 1", sat_flag); end
        repeat (3) beat(8'b11111111);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_sticky got %b want 1", sat_flag); end
        tie_bits = t; finish = 1; step(); finish = 0; step();
        checks++; if (out_valid !== 1'b1 || out_bits !== t) begin errors++; $display("FAIL sat_pos_zero got ov=%b bits=%b want ov=1 bits=%b", out_valid, out_bits, t); end
        start = 1; step(); start = 0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", sat_flag); end
        repeat (5) beat(8'b11111111);
        repeat (2) beat(8'b01010101);
        tie_bits = 4'b0000; finish = 1; step(); finish = 0; step();
        checks++; if (out_bits !== 4'b1111 || sat_flag !== 1'b1) begin errors++; $display("FAIL sat_neg got bits=%b sat=%b want bits=1111 sat=1", out_bits, sat_flag); end
    endtask

    task automatic test_restart();
        quiet(); start = 1; step(); start = 0;
        repeat (2) beat(8'b11111111);
        start = 1; sel_valid = 1; sel_bits = 8'b01010101; step(); quiet();
        checks++; if (beat_cnt !== 4'd1 || sat_flag !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart got beat=%0d sat=%b busy=%b want 1 0 1", beat_cnt, sat_flag, busy); end
        tie_bits = 4'b1111; finish = 1; step(); finish = 0; step();
        checks++; if (out_valid !== 1'b1 || out_bits !== 4'b0000) begin errors++; $display("FAIL restart_bits got ov=%b bits=%b want ov=1 bits=0000", out_valid, out_bits); end
        beat(8'b01010101);
        finish = 1; step(); finish = 0; step();
        checks++; if (beat_cnt !== 4'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore got beat=%0d busy=%b ov=%b want 1 0 0", beat_cnt, busy, out_valid); end
    endtask

    task automatic test_rst_in_resolve();
        quiet(); start = 1; step(); start = 0;
        beat(8'b01011101);
        finish = 1; step(); finish = 0;
        rst = 1; step(); rst = 0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || beat_cnt !== 4'd0 || sat_flag !== 1'b0 || out_bits !== 4'b0000) begin
            errors++; $display("FAIL rst_resolve got ov=%b busy=%b beat=%0d sat=%b bits=%b want all zero", out_valid, busy, beat_cnt, sat_flag, out_bits); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_resolve_late got ov=%b want 0", out_valid); end
    endtask

    task automatic test_start_in_resolve();
        quiet(); start = 1; step(); start = 0;
        beat(8'b01010101);
        finish = 1; step(); finish = 0;
        start = 1; step(); start = 0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || beat_cnt !== 4'd0) begin errors++; $display("FAIL start_resolve got ov=%b busy=%b beat=%0d want 0 1 0", out_valid, busy, beat_cnt); end
        step();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_resolve_late got ov=%b busy=%b want 0 1", out_valid, busy); end
    endtask

    task automatic test_illegal();
        logic [DIM-1:0] t;
        t = 4'($urandom);
        quiet(); start = 1; step(); start = 0;
        repeat (4) beat(8'b10101010);
        tie_bits = t; finish = 1; step(); finish = 0; step();
        checks++; if (out_bits !== t || beat_cnt !== 4'd4 || sat_flag !== 1'b0) begin errors++; $display("FAIL illegal got bits=%b beat=%0d sat=%b want %b 4 0", out_bits, beat_cnt, sat_flag, t); end
    endtask

    task automatic test_beat_saturation();
        quiet(); start = 1; step(); start = 0;
        repeat (20) beat(8'($urandom));
        checks++; if (beat_cnt !== 4'd15) begin errors++; $display("FAIL beat_sat got %0d want 15", beat_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            start     = ($urandom_range(0, 99) < 6);
            finish    = ($urandom_range(0, 99) < 12);
            sel_valid = ($urandom_range(0, 99) < 75);
            sel_bits  = 8'($urandom);
            tie_bits  = 4'($urandom);
            step();
            checks++;
            if (busy !== (m_state != 0) || out_valid !== m_ov || out_bits !== m_ob ||
                beat_cnt !== 4'(m_beat) || sat_flag !== m_sat) begin
                errors++;
                $display("FAIL random_%0d got busy=%b ov=%b bits=%b beat=%0d sat=%b want busy=%b ov=%b bits=%b beat=%0d sat=%b",
                         n, busy, out_valid, out_bits, beat_cnt, sat_flag,
                         (m_state != 0), m_ov, m_ob, m_beat, m_sat);
            end
        end
        quiet();
    endtask

    initial begin
        quiet();
        tie_bits = '0;
        m_state = 0; m_beat = 0; m_sat = 0; m_ov = 0; m_ob = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        test_reset();
        test_basic();
        test_finish_with_beat();
        test_saturation();
        test_restart();
        test_rst_in_resolve();
        test_start_in_resolve();
        test_illegal();
        test_beat_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
